// File: rtl/remover_frame_ctrl.sv
// Frame sequencer for the remover datapath: walks one active frame of pixel memory in raster
// order, feeds the remover, and tags its output with valid, x/y and line/frame markers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | issuing pixel reads (paused while hold=1)
// S_DRAIN | all pixels issued, waiting for the tag pipeline to empty
// S_DONE  | one-cycle completion pulse
module remover_frame_ctrl #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int ADDR_W  = 19,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int REM_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        rem_data,
    output logic              px_valid,
    output logic [X_W-1:0]    px_x,
    output logic [Y_W-1:0]    px_y,
    output logic              line_end,
    output logic              frame_end,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                NPIX      = H_ACT * V_ACT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(H_ACT - 1);

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic              issue, last_issue, pipe_busy;

    // Stage 0 lines up with mem_rd_data, stage REM_LAT with the remover output.
    logic [REM_LAT:0]  v_pipe, le_pipe, fe_pipe;
    logic [X_W-1:0]    x_pipe [REM_LAT+1];
    logic [Y_W-1:0]    y_pipe [REM_LAT+1];

    assign issue      = (state == S_FETCH) && !hold;
    assign last_issue = issue && (addr_cnt == LAST_ADDR);
    assign pipe_busy  = |v_pipe[REM_LAT-1:0];

    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? addr_cnt : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (last_issue) state_nxt = S_DRAIN;
            // The pixel sitting in the output stage now is the last one, so done follows frame_end.
            S_DRAIN: if (!pipe_busy) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Counters return to zero after the last issue so the address never passes the frame end.
    always_ff @(posedge clk) begin
        if (!rstn || abort || last_issue) begin
            addr_cnt <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else if (issue) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (x_cnt == LAST_X) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + Y_W'(1);
            end else begin
                x_cnt <= x_cnt + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            v_pipe  <= '0;
            le_pipe <= '0;
            fe_pipe <= '0;
            for (int i = 0; i <= REM_LAT; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
        end else begin
            v_pipe    <= {v_pipe[REM_LAT-1:0], issue};
            le_pipe   <= {le_pipe[REM_LAT-1:0], issue && (x_cnt == LAST_X)};
            fe_pipe   <= {fe_pipe[REM_LAT-1:0], last_issue};
            x_pipe[0] <= x_cnt;
            y_pipe[0] <= y_cnt;
            for (int i = 1; i <= REM_LAT; i++) begin
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
            end
        end
    end

    assign rem_data  = v_pipe[0] ? mem_rd_data : 8'h00;
    assign px_valid  = v_pipe[REM_LAT];
    assign px_x      = v_pipe[REM_LAT] ? x_pipe[REM_LAT] : '0;
    assign px_y      = v_pipe[REM_LAT] ? y_pipe[REM_LAT] : '0;
    assign line_end  = v_pipe[REM_LAT] && le_pipe[REM_LAT];
    assign frame_end = v_pipe[REM_LAT] && fe_pipe[REM_LAT];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_remover_frame_ctrl.sv
// Directed bench for remover_frame_ctrl on a 4x2 frame with a one-cycle read-latency memory model.
module tb_remover_frame_ctrl;

    logic       clk = 1'b0;
    logic       rstn, start, hold, abort;
    logic       mem_rd_en;
    logic [2:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic [7:0] rem_data;
    logic       px_valid;
    logic [1:0] px_x;
    logic [0:0] px_y;
    logic       line_end, frame_end, busy, done;

    logic [7:0] mem [8];
    int total = 0;
    int bad   = 0;

    remover_frame_ctrl #(
        .H_ACT(4), .V_ACT(2), .ADDR_W(3), .X_W(2), .Y_W(1), .REM_LAT(1)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .hold(hold), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .rem_data(rem_data), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
        .line_end(line_end), .frame_end(frame_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Garbage on non-read cycles exposes any missing rem_data gating.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= 8'h5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int icyc(input int a, input int hold_len);
        return (a < 3) ? a + 1 : a + 1 + hold_len;
    endfunction

    function automatic int find(input int j, input int hold_len);
        for (int a = 0; a < 8; a++)
            if (icyc(a, hold_len) == j) return a;
        return -1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " en"},    mem_rd_en, 0);
        chk({tag, " addr"},  mem_addr,  0);
        chk({tag, " rem"},   rem_data,  0);
        chk({tag, " valid"}, px_valid,  0);
        chk({tag, " x"},     px_x,      0);
        chk({tag, " y"},     px_y,      0);
        chk({tag, " le"},    line_end,  0);
        chk({tag, " fe"},    frame_end, 0);
        chk({tag, " done"},  done,      0);
        chk({tag, " busy"},  busy,      0);
    endtask

    // Start at j=0, then check every cycle until busy has dropped; hold covers j=4..3+hold_len.
    task automatic run_frame(input string tag, input int hold_len, input int restart_j);
        int last_px, a_iss, a_rem, a_px;
        string t;
        step();
        start = 1'b1;
        #1;
        chk({tag, " pre busy"}, busy, 0);
        last_px = icyc(7, hold_len) + 2;
        for (int j = 1; j <= last_px + 2; j++) begin
            step();
            start = (restart_j != 0) && (j == restart_j || j == restart_j + 1);
            hold  = (hold_len > 0) && (j >= 4) && (j < 4 + hold_len);
            #1;
            t = $sformatf("%s j%0d", tag, j);
            a_iss = find(j, hold_len);
            a_rem = find(j - 1, hold_len);
            a_px  = find(j - 2, hold_len);
            chk({t, " en"},    mem_rd_en, a_iss >= 0);
            chk({t, " addr"},  mem_addr,  (a_iss >= 0) ? a_iss : 0);
            chk({t, " rem"},   rem_data,  (a_rem >= 0) ? mem[a_rem] : 8'h00);
            chk({t, " valid"}, px_valid,  a_px >= 0);
            chk({t, " x"},     px_x,      (a_px >= 0) ? a_px % 4 : 0);
            chk({t, " y"},     px_y,      (a_px >= 0) ? a_px / 4 : 0);
            chk({t, " le"},    line_end,  (a_px >= 0) && (a_px % 4 == 3));
            chk({t, " fe"},    frame_end, a_px == 7);
            chk({t, " done"},  done,      j == last_px + 1);
            chk({t, " busy"},  busy,      j <= last_px + 1);
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        mem[0] = 8'b1_0100101;
        for (int i = 1; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        rstn = 1'b0; start = 1'b1; hold = 1'b0; abort = 1'b0;

        // Reset with start held high
        step();
        chk_quiet("rst1");
        step();
        chk_quiet("rst2");
        step();
        rstn = 1'b1;
        start = 1'b0;
        #1;
        chk_quiet("rst3");
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk_quiet($sformatf("post_rst%0d", i));
        end

        // Full frame, no hold, including rem_data = 8'hA5 at j=2
        run_frame("full", 0, 0);
        // Back-to-back start in the first cycle with busy=0
        run_frame("b2b", 0, 0);
        // Three-cycle hold after addr 2
        run_frame("hold", 3, 0);
        // start while busy is ignored
        run_frame("restart_busy", 0, 3);

        // Abort in the cycle addr 5 is issued
        step();
        start = 1'b1;
        #1;
        chk("abort pre busy", busy, 0);
        for (int j = 1; j <= 6; j++) begin
            step();
            start = 1'b0;
            abort = (j == 6);
            #1;
            chk($sformatf("abort j%0d en", j),   mem_rd_en, 1);
            chk($sformatf("abort j%0d addr", j), mem_addr,  j - 1);
        end
        chk("abort j6 valid", px_valid, 1);
        chk("abort j6 x",     px_x,     3);
        chk("abort j6 le",    line_end, 1);
        step();
        abort = 1'b0;
        #1;
        chk_quiet("abort j7");
        step();
        #1;
        chk_quiet("abort j8");
        run_frame("after_abort", 0, 0);

        // start and abort together in IDLE
        step();
        start = 1'b1;
        abort = 1'b1;
        #1;
        chk("sa busy0", busy, 0);
        step();
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk_quiet("sa1");
        step();
        #1;
        chk_quiet("sa2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
